// File: rtl/vga_tile_sequencer_if.sv
// vga_tile_sequencer_if: raster timing in, tile position/colour/mode out
interface vga_tile_sequencer_if;
  logic       i_Frame_Start;
  logic       i_Line_Start;
  logic       i_Active;
  logic       i_Mode_Next;
  logic [4:0] o_Col;
  logic [3:0] o_Row;
  logic [2:0] o_Red;
  logic [2:0] o_Grn;
  logic [2:0] o_Blu;
  logic [1:0] o_Mode;
  logic       o_Mode_Pending;
  modport master (
    output i_Frame_Start, i_Line_Start, i_Active, i_Mode_Next,
    input  o_Col, o_Row, o_Red, o_Grn, o_Blu, o_Mode, o_Mode_Pending
  );
  modport slave (
    input  i_Frame_Start, i_Line_Start, i_Active, i_Mode_Next,
    output o_Col, o_Row, o_Red, o_Grn, o_Blu, o_Mode, o_Mode_Pending
  );
endinterface

// File: rtl/vga_tile_sequencer.sv
// vga_tile_sequencer: tile counters, tear-free mode FSM and 2-cycle colour pipeline
module vga_tile_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int TILE_W   = 20,
  parameter int TILE_H   = 30
) (
  input logic                 i_Clk,
  input logic                 i_Reset_n,
  vga_tile_sequencer_if.slave bus
);
  localparam int PW = $clog2(TILE_W);
  localparam int LW = $clog2(TILE_H);
  localparam logic [PW-1:0] PIX_LAST  = PW'(TILE_W - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(TILE_H - 1);
  localparam logic [4:0]    COL_LAST  = 5'(H_ACTIVE / TILE_W - 1);
  localparam logic [3:0]    ROW_LAST  = 4'(V_ACTIVE / TILE_H - 1);
  typedef enum logic {RUN, PEND} state_t;
  state_t        state_q, state_d;
  logic [1:0]    rs_q, rs_d;
  logic          rst_n;
  logic [PW-1:0] pix_q, pix_d, pix_cur;
  logic [LW-1:0] line_q, line_d;
  logic [4:0]    col_q, col_d, col_cur;
  logic [3:0]    row_q, row_d;
  logic          sync_q, sync_d, mn_q, mn_d;
  logic [1:0]    mode_q, mode_d;
  logic          new_line, pix_wrap, line_wrap, rise, on;
  logic [4:0]    s1_col_q;
  logic [2:0]    s1_row_q, chk, grey;
  logic [1:0]    s1_mode_q;
  logic          s1_act_q;
  logic [2:0]    red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  // Asserts asynchronously, releases two clocks after i_Reset_n rises
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) rs_q <= '0;
    else rs_q <= rs_d;
  assign rst_n = rs_q[1];
  // Tile counters track the raster; the current pixel's tile is resolved combinationally
  always_comb begin
    rs_d      = {rs_q[0], 1'b1};
    new_line  = bus.i_Frame_Start | bus.i_Line_Start;
    pix_cur   = new_line ? '0 : pix_q;
    col_cur   = new_line ? '0 : col_q;
    pix_wrap  = pix_cur == PIX_LAST;
    pix_d     = !bus.i_Active ? pix_cur : pix_wrap ? '0 : pix_cur + 1'b1;
    col_d     = (bus.i_Active && pix_wrap && col_cur != COL_LAST) ? col_cur + 1'b1 : col_cur;
    line_wrap = line_q == LINE_LAST;
    line_d    = bus.i_Frame_Start ? '0 : !bus.i_Line_Start ? line_q : line_wrap ? '0 : line_q + 1'b1;
    row_d     = bus.i_Frame_Start ? '0 :
                (bus.i_Line_Start && line_wrap && row_q != ROW_LAST) ? row_q + 1'b1 : row_q;
    sync_d    = sync_q | bus.i_Frame_Start;
    mn_d      = bus.i_Mode_Next;
    rise      = bus.i_Mode_Next & ~mn_q;
  end
  // Mode FSM state register
  always_ff @(posedge i_Clk or negedge rst_n)
    if (!rst_n) state_q <= RUN;
    else state_q <= state_d;
  // A request waits in PEND for a frame start; extra edges while pending are dropped
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && rise) state_d = PEND;
    if (state_q == PEND && bus.i_Frame_Start) state_d = RUN;
  end
  // Mode advances in the frame-start cycle so stage 1 sees it for the whole new frame
  always_comb begin
    mode_d             = (state_q == PEND && bus.i_Frame_Start) ? mode_q + 1'b1 : mode_q;
    bus.o_Mode_Pending = state_q == PEND;
  end
  // Counters, flags and both pipeline stages
  always_ff @(posedge i_Clk or negedge rst_n)
    if (!rst_n) begin
      pix_q     <= '0;
      line_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      sync_q    <= 1'b0;
      mn_q      <= 1'b0;
      mode_q    <= '0;
      s1_col_q  <= '0;
      s1_row_q  <= '0;
      s1_mode_q <= '0;
      s1_act_q  <= 1'b0;
      red_q     <= '0;
      grn_q     <= '0;
      blu_q     <= '0;
    end else begin
      pix_q     <= pix_d;
      line_q    <= line_d;
      col_q     <= col_d;
      row_q     <= row_d;
      sync_q    <= sync_d;
      mn_q      <= mn_d;
      mode_q    <= mode_d;
      s1_col_q  <= col_cur;
      s1_row_q  <= row_d[2:0];
      s1_mode_q <= mode_d;
      s1_act_q  <= bus.i_Active;
      red_q     <= red_d;
      grn_q     <= grn_d;
      blu_q     <= blu_d;
    end
  // Stage-2 colour lookup; black outside active video or before the first frame start
  always_comb begin
    on    = s1_act_q & sync_q;
    chk   = {3{s1_col_q[0] ^ s1_row_q[0]}};
    grey  = s1_col_q[4:2];
    red_d = !on ? '0 : s1_mode_q == 2'd0 ? s1_col_q[2:0] : s1_mode_q == 2'd1 ? grey :
            s1_mode_q == 2'd2 ? chk : 3'd7;
    grn_d = !on ? '0 : s1_mode_q == 2'd0 ? s1_row_q : s1_mode_q == 2'd1 ? grey :
            s1_mode_q == 2'd2 ? chk : 3'd0;
    blu_d = !on ? '0 : s1_mode_q == 2'd0 ? ~s1_col_q[2:0] : s1_mode_q == 2'd1 ? grey :
            s1_mode_q == 2'd2 ? chk : 3'd0;
  end
  assign bus.o_Col  = col_cur;
  assign bus.o_Row  = row_d;
  assign bus.o_Mode = mode_q;
  assign bus.o_Red  = red_q;
  assign bus.o_Grn  = grn_q;
  assign bus.o_Blu  = blu_q;
endmodule

// File: tb/tb_vga_tile_sequencer.sv
// tb_vga_tile_sequencer: directed raster stimulus with a colour scoreboard and mode model
module tb_vga_tile_sequencer;
  logic clk, rst_n, mn_lvl;
  int total = 0, bad = 0;
  int m_x, m_y, m_mode, m_pend, m_sync;
  logic m_prev;
  logic [8:0] q[$];
  vga_tile_sequencer_if bus();
  vga_tile_sequencer dut (.i_Clk(clk), .i_Reset_n(rst_n), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
  function automatic logic [8:0] mrgb(input int c, input int r, input int m);
    logic [2:0] ch;
    ch = ((c % 2) != (r % 2)) ? 3'd7 : 3'd0;
    case (m)
      0:       return {c[2:0], r[2:0], ~c[2:0]};
      1:       return {3{c[4:2]}};
      2:       return {3{ch}};
      default: return 9'o700;
    endcase
  endfunction
  task automatic model_reset();
    m_x = 0; m_y = 0; m_mode = 0; m_pend = 0; m_sync = 0; m_prev = 1'b0;
    q.delete();
  endtask
  task automatic step(input logic fs, input logic ls, input logic act);
    int c, r;
    logic rise;
    logic [8:0] e;
    bus.i_Frame_Start = fs;
    bus.i_Line_Start  = ls;
    bus.i_Active      = act;
    bus.i_Mode_Next   = mn_lvl;
    rise   = mn_lvl & ~m_prev;
    m_prev = mn_lvl;
    if (fs) begin m_x = 0; m_y = 0; m_sync = 1; end
    else if (ls) begin m_x = 0; m_y++; end
    if (m_pend != 0) begin
      if (fs) begin m_mode = (m_mode + 1) % 4; m_pend = 0; end
    end else if (rise) m_pend = 1;
    c = (m_x / 20 > 31) ? 31 : m_x / 20;
    r = (m_y / 30 > 15) ? 15 : m_y / 30;
    q.push_back((act && m_sync != 0) ? mrgb(c, r, m_mode) : 9'd0);
    #1;
    chk("col", bus.o_Col, c);
    chk("row", bus.o_Row, r);
    if (act) m_x++;
    @(posedge clk);
    #1;
    chk("mode", bus.o_Mode, m_mode);
    chk("pending", bus.o_Mode_Pending, m_pend);
    if (q.size() == 2) begin
      e = q.pop_front();
      chk("rgb", {bus.o_Red, bus.o_Grn, bus.o_Blu}, e);
    end
  endtask
  task automatic line(input logic fs, input int n);
    step(fs, 1'b1, 1'b1);
    repeat (n - 1) step(1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0);
  endtask
  task automatic mode_edge();
    mn_lvl = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    mn_lvl = 1'b0;
    step(1'b0, 1'b0, 1'b0);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_rgb"}, {bus.o_Red, bus.o_Grn, bus.o_Blu}, 0);
    chk({tag, "_mode"}, bus.o_Mode, 0);
    chk({tag, "_pend"}, bus.o_Mode_Pending, 0);
    chk({tag, "_col"}, bus.o_Col, 0);
    chk({tag, "_row"}, bus.o_Row, 0);
  endtask
  initial begin
    mn_lvl = 1'b0;
    rst_n  = 1'b0;
    bus.i_Frame_Start = 1'b0;
    bus.i_Line_Start  = 1'b0;
    bus.i_Active      = 1'b0;
    bus.i_Mode_Next   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("por");
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    line(1'b0, 30);
    line(1'b1, 40);
    line(1'b0, 700);
    chk("col_sat", bus.o_Col, 31);
    line(1'b1, 640);
    repeat (30) line(1'b0, 640);
    chk("row_line30", bus.o_Row, 1);
    mode_edge();
    chk("req_pend", bus.o_Mode_Pending, 1);
    chk("req_mode", bus.o_Mode, 0);
    line(1'b0, 20);
    line(1'b1, 100);
    chk("applied_mode", bus.o_Mode, 1);
    repeat (3) mode_edge();
    line(1'b1, 30);
    chk("three_edges", bus.o_Mode, 2);
    mn_lvl = 1'b1;
    line(1'b1, 30);
    mn_lvl = 1'b0;
    chk("coinc_mode", bus.o_Mode, 2);
    chk("coinc_pend", bus.o_Mode_Pending, 1);
    line(1'b1, 30);
    chk("coinc_next", bus.o_Mode, 3);
    mode_edge();
    bus.i_Frame_Start = 1'b0;
    bus.i_Line_Start  = 1'b0;
    bus.i_Active      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    line(1'b0, 40);
    for (int k = 1; k <= 4; k++) begin
      mode_edge();
      line(1'b1, 40);
      if (k == 2) repeat (30) line(1'b0, 40);
      chk("seq_mode", bus.o_Mode, k % 4);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
